// File: rtl/window_column_fetch.sv
// Fetches one window of message columns starting at a sampled scroll index and
// streams them, one column per beat, to the panel driver over valid/ready.
module window_column_fetch #(
    parameter int unsigned MSG_COLS = 48,
    parameter int unsigned WIN_COLS = 24,
    parameter int unsigned ROWS     = 8,
    parameter int unsigned IDX_W    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] start,
    input  logic             frame_req,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_addr,
    input  logic [ROWS-1:0]  mem_rdata,
    output logic [ROWS-1:0]  col_data,
    output logic [4:0]       col_idx,
    output logic             col_valid,
    input  logic             col_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned K_W   = 5;
    localparam int unsigned SUM_W = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        OUT     = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] start_q, start_d;
    logic             blank_q, blank_d;
    logic [K_W-1:0]   k, k_d;
    logic             rd_en_d;
    logic [IDX_W-1:0] addr_d;
    logic [ROWS-1:0]  data_d;
    logic [K_W-1:0]   idx_d;
    logic             valid_d;
    logic             busy_d;
    logic             done_d;

    logic [K_W-1:0]   k_inc_c;
    logic [SUM_W-1:0] sum_c;
    logic [IDX_W-1:0] next_addr_c;

    // Address of the next column; one subtract covers wrap since start_q < MSG_COLS.
    always_comb begin
        k_inc_c     = k + K_W'(1);
        sum_c       = {1'b0, start_q} + SUM_W'(k_inc_c);
        next_addr_c = (sum_c >= SUM_W'(MSG_COLS)) ? IDX_W'(sum_c - SUM_W'(MSG_COLS))
                                                  : IDX_W'(sum_c);
    end

    // Next-state and next registered-output values.
    always_comb begin
        state_d = state;
        start_d = start_q;
        blank_d = blank_q;
        k_d     = k;
        rd_en_d = 1'b0;
        addr_d  = mem_addr;
        data_d  = col_data;
        idx_d   = col_idx;
        valid_d = col_valid;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                if (frame_req) begin
                    start_d = start;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    if (start < IDX_W'(MSG_COLS)) begin
                        blank_d = 1'b0;
                        rd_en_d = 1'b1;
                        addr_d  = start;
                        state_d = READ;
                    end else begin
                        // Out-of-range index: emit a blank frame without touching memory.
                        blank_d = 1'b1;
                        data_d  = '0;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        state_d = OUT;
                    end
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d  = mem_rdata;
                idx_d   = k;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (col_ready) begin
                    if (k == K_W'(WIN_COLS - 1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (blank_q) begin
                        k_d   = k_inc_c;
                        idx_d = k_inc_c;
                        data_d = '0;
                    end else begin
                        k_d     = k_inc_c;
                        valid_d = 1'b0;
                        rd_en_d = 1'b1;
                        addr_d  = next_addr_c;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_q    <= '0;
            blank_q    <= 1'b0;
            k          <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            col_data   <= '0;
            col_idx    <= '0;
            col_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            start_q    <= start_d;
            blank_q    <= blank_d;
            k          <= k_d;
            mem_rd_en  <= rd_en_d;
            mem_addr   <= addr_d;
            col_data   <= data_d;
            col_idx    <= idx_d;
            col_valid  <= valid_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule
